// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
package pipe_pkg;
   localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;
endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus PC, instruction and packed payload.
// Priority: reset > kill (bubble carrying kill_pc) > load > clear.
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   clear,
   input  logic                   kill,
   input  logic [WIDTH-1:0]       kill_pc,
   input  logic [WIDTH-1:0]       d_pc,
   input  logic [WIDTH-1:0]       d_instr,
   input  logic [LANES*WIDTH-1:0] d_payload,
   output logic                   q_valid,
   output logic [WIDTH-1:0]       q_pc,
   output logic [WIDTH-1:0]       q_instr,
   output logic [LANES*WIDTH-1:0] q_payload
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid   <= 1'b0;
         q_pc      <= '0;
         q_instr   <= '0;
         q_payload <= '0;
      end else if (kill) begin
         q_valid   <= 1'b0;
         q_pc      <= kill_pc;
         q_instr   <= '0;
         q_payload <= '0;
      end else if (load) begin
         q_valid   <= 1'b1;
         q_pc      <= d_pc;
         q_instr   <= d_instr;
         q_payload <= d_payload;
      end else if (clear) begin
         // data is kept; the top gates instr/payload while invalid
         q_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, flush bubble and exception (handler PC) bubble.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int             WIDTH  = 32,
   parameter int             LANES  = 4,
   parameter logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_HANDLER_PC),
   parameter bit             SKID   = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_pc,
   input  logic [WIDTH-1:0]       in_instr,
   input  logic [LANES*WIDTH-1:0] in_payload,
   input  logic                   flush,
   input  logic                   req,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_pc,
   output logic [WIDTH-1:0]       out_instr,
   output logic [LANES*WIDTH-1:0] out_payload
);

   logic                   kill;
   logic [WIDTH-1:0]       kill_pc;
   logic                   accept;
   logic                   consume;
   logic                   main_load;
   logic                   main_clear;
   logic                   main_valid;
   logic [WIDTH-1:0]       main_pc;
   logic [WIDTH-1:0]       main_instr;
   logic [LANES*WIDTH-1:0] main_payload;
   logic [WIDTH-1:0]       main_d_pc;
   logic [WIDTH-1:0]       main_d_instr;
   logic [LANES*WIDTH-1:0] main_d_payload;

   // req outranks flush: the bubble carries the handler PC
   assign kill    = req | flush;
   assign kill_pc = req ? EXC_PC : '0;
   assign accept  = in_valid & in_ready;
   assign consume = main_valid & out_ready;

   pipe_entry_reg #(.WIDTH(WIDTH), .LANES(LANES)) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (main_load),
      .clear     (main_clear),
      .kill      (kill),
      .kill_pc   (kill_pc),
      .d_pc      (main_d_pc),
      .d_instr   (main_d_instr),
      .d_payload (main_d_payload),
      .q_valid   (main_valid),
      .q_pc      (main_pc),
      .q_instr   (main_instr),
      .q_payload (main_payload)
   );

   generate
      if (SKID) begin : g_skid
         logic                   skid_valid;
         logic [WIDTH-1:0]       skid_pc;
         logic [WIDTH-1:0]       skid_instr;
         logic [LANES*WIDTH-1:0] skid_payload;
         logic                   skid_load;
         logic                   skid_clear;
         logic                   skid_valid_next;
         logic                   in_ready_reg;

         // main refills from skid when draining, else straight from input
         assign main_load      = (accept & (!main_valid | consume) & !skid_valid)
                               | (consume & skid_valid);
         assign main_clear     = consume;
         assign main_d_pc      = skid_valid ? skid_pc      : in_pc;
         assign main_d_instr   = skid_valid ? skid_instr   : in_instr;
         assign main_d_payload = skid_valid ? skid_payload : in_payload;

         assign skid_load       = accept & main_valid & (!consume | skid_valid);
         assign skid_clear      = consume & skid_valid;
         assign skid_valid_next = skid_load | (skid_valid & !skid_clear);

         pipe_entry_reg #(.WIDTH(WIDTH), .LANES(LANES)) u_skid (
            .clk       (clk),
            .reset     (reset),
            .load      (skid_load),
            .clear     (skid_clear),
            .kill      (kill),
            .kill_pc   ('0),
            .d_pc      (in_pc),
            .d_instr   (in_instr),
            .d_payload (in_payload),
            .q_valid   (skid_valid),
            .q_pc      (skid_pc),
            .q_instr   (skid_instr),
            .q_payload (skid_payload)
         );

         always_ff @(posedge clk) begin
            if (reset)
               in_ready_reg <= 1'b0;
            else if (kill)
               in_ready_reg <= 1'b1;
            else
               in_ready_reg <= !skid_valid_next;
         end

         assign in_ready = in_ready_reg;
      end else begin : g_noskid
         assign main_load      = accept;
         assign main_clear     = consume;
         assign main_d_pc      = in_pc;
         assign main_d_instr   = in_instr;
         assign main_d_payload = in_payload;
         assign in_ready       = !main_valid | out_ready;
      end
   endgenerate

   assign out_valid   = main_valid;
   assign out_pc      = main_pc;
   assign out_instr   = main_valid ? main_instr   : '0;
   assign out_payload = main_valid ? main_payload : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance plus a SKID=0 instance.
module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [31:0]  in_pc;
   logic [31:0]  in_instr;
   logic [127:0] in_payload;
   logic         flush;
   logic         req;
   logic         out_ready;

   logic         in_ready,  out_valid;
   logic [31:0]  out_pc,    out_instr;
   logic [127:0] out_payload;
   logic         in_ready0, out_valid0;
   logic [31:0]  out_pc0,   out_instr0;
   logic [127:0] out_payload0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .LANES(4), .SKID(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload),
      .flush(flush), .req(req), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_payload(out_payload)
   );

   pipe_stage_reg #(.WIDTH(32), .LANES(4), .SKID(1'b0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload),
      .flush(flush), .req(req), .out_valid(out_valid0), .out_ready(out_ready),
      .out_pc(out_pc0), .out_instr(out_instr0), .out_payload(out_payload0)
   );

   function automatic logic [127:0] mk_pay(input logic [31:0] pc);
      return {pc + 32'h300, pc + 32'h200, pc + 32'h100, pc};
   endfunction

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic offer(input logic v, input logic [31:0] pc);
      in_valid   = v;
      in_pc      = pc;
      in_instr   = mk_instr(pc);
      in_payload = mk_pay(pc);
   endtask

   // advance one edge; outputs are sampled 1ns later
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; req = 1'b0; out_ready = 1'b1;
      offer(1'b1, 32'h1234);
      cyc(); cyc();
      total++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_payload !== 128'h0 || out_instr !== 32'h0) begin
         bad++;
         $display("FAIL reset_outs valid=%b pc=%h instr=%h pay=%h required 0/0/0/0",
                  out_valid, out_pc, out_instr, out_payload);
      end
      reset = 1'b0;
      cyc();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
      offer(1'b0, 32'h0);
      $display("reset: out_valid=%b out_pc=%h in_ready=%b", out_valid, out_pc, in_ready);
   endtask

   task automatic test_throughput();
      logic [31:0] pc;
      out_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         pc = 32'h3000 + 32'(4 * n);
         offer(1'b1, pc);
         cyc();
         total++;
         if (out_valid !== 1'b1 || out_pc !== pc || out_instr !== mk_instr(pc)
             || out_payload !== mk_pay(pc) || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL thru_%0d valid=%b pc=%h instr=%h in_ready=%b required 1/%h/%h/1",
                     n, out_valid, out_pc, out_instr, in_ready, pc, mk_instr(pc));
         end
         $display("thru: n=%0d out_pc=%h", n, out_pc);
      end
      offer(1'b0, 32'h0);
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL thru_drain out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      offer(1'b1, 32'h3000);
      cyc();
      offer(1'b1, 32'h3004);
      cyc();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h3000) begin
         bad++;
         $display("FAIL bp_full in_ready=%b valid=%b pc=%h required 0/1/00003000",
                  in_ready, out_valid, out_pc);
      end
      offer(1'b1, 32'h3008);
      cyc();
      total++;
      if (in_ready !== 1'b0 || out_pc !== 32'h3000 || out_instr !== mk_instr(32'h3000)) begin
         bad++;
         $display("FAIL bp_stall in_ready=%b pc=%h instr=%h required 0/00003000/%h",
                  in_ready, out_pc, out_instr, mk_instr(32'h3000));
      end
      $display("bp: head=%h held, releasing", out_pc);
      out_ready = 1'b1;
      cyc();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3004 || out_payload !== mk_pay(32'h3004)
          || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_second valid=%b pc=%h in_ready=%b required 1/00003004/1",
                  out_valid, out_pc, in_ready);
      end
      cyc();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3008) begin
         bad++;
         $display("FAIL bp_third valid=%b pc=%h required 1/00003008", out_valid, out_pc);
      end
      offer(1'b0, 32'h0);
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_empty out_valid=%b required 0", out_valid);
      end
      $display("bp: drained in order");
   endtask

   task automatic test_exception();
      out_ready = 1'b0;
      offer(1'b1, 32'h3100);
      cyc();
      offer(1'b1, 32'h3104);
      cyc();
      offer(1'b1, 32'h3108);
      req = 1'b1;
      cyc();
      total++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0000_4180 || out_instr !== 32'h0
          || out_payload !== 128'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL exc_bubble valid=%b pc=%h instr=%h in_ready=%b required 0/00004180/0/1",
                  out_valid, out_pc, out_instr, in_ready);
      end
      req = 1'b0;
      offer(1'b0, 32'h0);
      out_ready = 1'b1;
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL exc_dropped out_valid=%b pc=%h required valid 0", out_valid, out_pc);
      end
      $display("exc: bubble pc=00004180 checked");
   endtask

   task automatic test_flush_vs_req();
      out_ready = 1'b0;
      offer(1'b1, 32'h3200);
      cyc();
      offer(1'b1, 32'h3204);
      flush = 1'b1; req = 1'b1;
      cyc();
      total++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0000_4180) begin
         bad++;
         $display("FAIL flush_req valid=%b pc=%h required 0/00004180", out_valid, out_pc);
      end
      req = 1'b0;
      offer(1'b1, 32'h3208);
      cyc();
      total++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
         bad++;
         $display("FAIL flush_only valid=%b pc=%h instr=%h required 0/0/0", out_valid, out_pc, out_instr);
      end
      flush = 1'b0;
      offer(1'b0, 32'h0);
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_drop out_valid=%b required 0", out_valid);
      end
      $display("flush: req priority and plain flush checked");
   endtask

   task automatic test_skid0();
      reset = 1'b1;
      out_ready = 1'b0;
      offer(1'b0, 32'h0);
      cyc();
      reset = 1'b0;
      #1;
      total++;
      if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL s0_empty in_ready=%b valid=%b required 1/0", in_ready0, out_valid0);
      end
      offer(1'b1, 32'h3300);
      cyc();
      total++;
      if (out_valid0 !== 1'b1 || out_pc0 !== 32'h3300 || out_payload0 !== mk_pay(32'h3300)) begin
         bad++;
         $display("FAIL s0_load valid=%b pc=%h required 1/00003300", out_valid0, out_pc0);
      end
      offer(1'b1, 32'h3304);
      #1;
      total++;
      if (in_ready0 !== 1'b0) begin
         bad++;
         $display("FAIL s0_stall in_ready=%b required 0", in_ready0);
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready0 !== 1'b1) begin
         bad++;
         $display("FAIL s0_comb_ready in_ready=%b required 1", in_ready0);
      end
      cyc();
      total++;
      if (out_valid0 !== 1'b1 || out_pc0 !== 32'h3304 || out_instr0 !== mk_instr(32'h3304)) begin
         bad++;
         $display("FAIL s0_pass valid=%b pc=%h instr=%h required 1/00003304/%h",
                  out_valid0, out_pc0, out_instr0, mk_instr(32'h3304));
      end
      offer(1'b0, 32'h0);
      cyc();
      total++;
      if (out_valid0 !== 1'b0 || out_instr0 !== 32'h0 || out_payload0 !== 128'h0
          || out_pc0 !== 32'h3304) begin
         bad++;
         $display("FAIL s0_gate valid=%b instr=%h pc=%h required 0/0/00003304",
                  out_valid0, out_instr0, out_pc0);
      end
      $display("skid0: stall, same-cycle reload and gating checked");
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; req = 1'b0; out_ready = 1'b0;
      offer(1'b0, 32'h0);
      test_reset();
      test_throughput();
      test_back_to_back();
      test_exception();
      test_flush_vs_req();
      test_skid0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
